dmem_responder: RTL

Data-memory responder for the pipelined MIPS core's memory stage. It answers the core's data port: `memwriteM`, `aluoutM` (byte address), `writedataM`, and returns `readdataM` in the same cycle. Stores are posted into a small write buffer that drains into a word-addressed RAM. An external loader port can steal RAM write cycles, for program/data preload or a DMA agent. Reads forward from the buffer, so the core always sees its own latest store without stalling.

---
 rtl/dmem_responder.sv | 132 +++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// dmem_responder
//   Data-memory responder for the memory stage of a pipelined MIPS core.
//   Core stores go into a small circular write buffer, and the buffer drains
//   into a word-addressed RAM. An external loader can take the RAM write port
//   in any cycle. Loads are combinational. They forward from the newest
//   matching buffered store, so the core always sees its own latest write.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   memwriteM    core store request
//   aluoutM      core byte address (word index = aluoutM[AW+1:2])
//   writedataM   core store data
//   readdataM    combinational load data for aluoutM
//   ld_we        loader write strobe (wins over buffer drain)
//   ld_addr      loader word address
//   ld_data      loader write data
//   wbuf_count   occupied write-buffer entries
//   wbuf_full    buffer holds WBUF_DEPTH entries
//   err_overflow sticky: a store was dropped because the buffer was full
//   err_misalign sticky: a store with aluoutM[1:0] != 0 was dropped
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WBUF_DEPTH  = 4,
    localparam int AW = $clog2(DEPTH_WORDS),
    localparam int PW = $clog2(WBUF_DEPTH),
    localparam int CW = PW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          memwriteM,
    input  logic [31:0]   aluoutM,
    input  logic [31:0]   writedataM,
    output logic [31:0]   readdataM,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_addr,
    input  logic [31:0]   ld_data,
    output logic [CW-1:0] wbuf_count,
    output logic          wbuf_full,
    output logic          err_overflow,
    output logic          err_misalign
);

    logic [31:0]   ram     [DEPTH_WORDS];
    logic [AW-1:0] wb_addr [WBUF_DEPTH];
    logic [31:0]   wb_data [WBUF_DEPTH];

    logic [PW-1:0] head, tail;
    logic [CW-1:0] count;

    logic [AW-1:0] word_idx;
    logic          aligned;
    logic          full;
    logic          pop;
    logic          push;
    logic          overflow;

    // Byte offset and the bits above the RAM range are ignored on loads, so
    // the RAM aliases modulo its size.
    logic          unused_hi;
    assign unused_hi = ^aluoutM[31:AW+2];

    assign word_idx = aluoutM[AW+1:2];
    assign aligned  = (aluoutM[1:0] == 2'b00);
    assign full     = (count == CW'(WBUF_DEPTH));

    // The loader owns the RAM write port in any cycle it strobes.
    assign pop      = (count != '0) && !ld_we;
    // A full buffer still takes a store when the head drains this same edge.
    assign push     = memwriteM && aligned && (!full || pop);
    assign overflow = memwriteM && aligned && full && !pop;

    // NOTE: registers update with non-blocking assignments, so every
    // process samples the values from before the edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            err_overflow <= 1'b0;
            err_misalign <= 1'b0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            if (overflow)                 err_overflow <= 1'b1;
            if (memwriteM && !aligned)    err_misalign <= 1'b1;
        end
    end

    // NOTE: storage arrays have no reset. Validity comes only from
    // head/count, and an unreset array maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            wb_addr[tail] <= word_idx;
            wb_data[tail] <= writedataM;
        end
    end

    always_ff @(posedge clk) begin
        if (ld_we)
            ram[ld_addr] <= ld_data;
        else if (pop)
            ram[wb_addr[head]] <= wb_data[head];
    end

    // Scan the valid entries from oldest to newest. The last match overrides
    // the earlier ones, so the newest store wins.
    logic [31:0]   rd_data;
    logic [PW-1:0] slot;

    // NOTE: every variable assigned here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        rd_data = ram[word_idx];
        slot    = '0;
        for (int k = 0; k < WBUF_DEPTH; k++) begin
            slot = head + PW'(k);
            if ((CW'(k) < count) && (wb_addr[slot] == word_idx))
                rd_data = wb_data[slot];
        end
    end

    assign readdataM  = rd_data;
    assign wbuf_count = count;
    assign wbuf_full  = full;

endmodule
